// File: rtl/cpu_register_file.sv
// RV32 architectural register file: tag-handshaked writeback, two registered read ports,
// retired counter and post-reset zero sweep. Optional macro RV32_REGFILE_BYPASS_EN adds write-to-read forwarding.
module cpu_register_file (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [7:0]  i_tag,
    input  logic [4:0]  i_inst_rd,
    input  logic [31:0] i_rd,
    input  logic [31:0] i_pc_next,
    input  logic [4:0]  i_inst_rs1,
    input  logic [4:0]  i_inst_rs2,
    output logic [31:0] o_rs1,
    output logic [31:0] o_rs2,
    output logic [7:0]  o_tag,
    output logic [31:0] o_pc_next,
    output logic [63:0] o_retired,
    output logic        o_ready
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  tag_q, tag_d;
    logic [31:0] pc_q, pc_d;
    logic [63:0] retired_q, retired_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;

    logic [31:0] regs_q [32];

    logic        consume;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    // NOTE: every signal assigned in always_comb gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        consume = 1'b0;
        wr_en   = 1'b0;
        wr_addr = i_inst_rd;
        wr_data = i_rd;
        case (state_q)
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = idx_q;
                wr_data = '0;
                idx_d   = idx_q + 5'd1;
                if (idx_q == 5'd31) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                // A tag differing from the last consumed one is a fresh writeback.
                consume = (i_tag != tag_q);
                wr_en   = consume && (i_inst_rd != 5'd0);
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_comb begin
        tag_d     = tag_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        if (consume) begin
            tag_d     = i_tag;
            pc_d      = i_pc_next;
            retired_d = retired_q + 64'd1;
        end
    end

    // x0 and every read during the sweep return zero.
    always_comb begin
        rs1_d = '0;
        rs2_d = '0;
        if (state_q == ST_READY) begin
            if (i_inst_rs1 != 5'd0) begin
                rs1_d = regs_q[i_inst_rs1];
            end
            if (i_inst_rs2 != 5'd0) begin
                rs2_d = regs_q[i_inst_rs2];
            end
`ifdef RV32_REGFILE_BYPASS_EN
            if (wr_en && (wr_addr == i_inst_rs1)) begin
                rs1_d = wr_data;
            end
            if (wr_en && (wr_addr == i_inst_rs2)) begin
                rs2_d = wr_data;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q   <= ST_CLEAR;
            idx_q     <= 5'd1;
            tag_q     <= '0;
            pc_q      <= '0;
            retired_q <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tag_q     <= tag_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
        end
    end

    // NOTE: the array has no reset; the post-reset sweep clears it so it maps onto plain RAM/flops.
    always_ff @(posedge i_clock) begin
        if (i_reset_n && wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign o_rs1     = rs1_q;
    assign o_rs2     = rs2_q;
    assign o_tag     = tag_q;
    assign o_pc_next = pc_q;
    assign o_retired = retired_q;
    assign o_ready   = (state_q == ST_READY);

endmodule

// File: tb/tb_cpu_register_file.sv
// Directed self-checking bench for cpu_register_file: sweep timing, writeback, x0, hold, bypass,
// back-to-back stream with mid-stream reset, and tag presented during the sweep.
module tb_cpu_register_file;

    logic        clk;
    logic        rst_n;
    logic [7:0]  tag;
    logic [4:0]  rd_idx;
    logic [31:0] rd_val;
    logic [31:0] pc_in;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_out;
    logic [31:0] rs2_out;
    logic [7:0]  tag_out;
    logic [31:0] pc_out;
    logic [63:0] retired_out;
    logic        ready_out;

    int checks = 0;
    int errors = 0;

    cpu_register_file dut (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .i_tag      (tag),
        .i_inst_rd  (rd_idx),
        .i_rd       (rd_val),
        .i_pc_next  (pc_in),
        .i_inst_rs1 (rs1_idx),
        .i_inst_rs2 (rs2_idx),
        .o_rs1      (rs1_out),
        .o_rs2      (rs2_out),
        .o_tag      (tag_out),
        .o_pc_next  (pc_out),
        .o_retired  (retired_out),
        .o_ready    (ready_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tag = 8'd0; rd_idx = 5'd0; rd_val = '0; pc_in = '0;
        rs1_idx = 5'd0; rs2_idx = 5'd0;
        step();
        step();
        checks++;
        if ({rs1_out, rs2_out, tag_out, pc_out, retired_out, ready_out} !== '0) begin
            errors++;
            $display("FAIL reset_values: rs1=%h rs2=%h tag=%h pc=%h ret=%h rdy=%b (all must be 0)",
                     rs1_out, rs2_out, tag_out, pc_out, retired_out, ready_out);
        end
        rst_n = 1'b1;
        checks++;
        if (ready_out !== 1'b0) begin
            errors++; $display("FAIL ready_cycle1: got %b expected 0", ready_out);
        end
        for (int k = 1; k <= 31; k++) begin
            step();
            checks++;
            if (ready_out !== (k == 31)) begin
                errors++; $display("FAIL sweep_ready edge %0d: got %b expected %b", k, ready_out, (k == 31));
            end
        end
        for (int a = 1; a <= 31; a++) begin
            rs1_idx = a[4:0];
            step();
            checks++;
            if (rs1_out !== 32'h0) begin
                errors++; $display("FAIL swept_read x%0d: got %h expected 0", a, rs1_out);
            end
        end
    endtask

    task automatic test_basic_write();
        rs1_idx = 5'd0;
        tag = 8'd1; rd_idx = 5'd5; rd_val = 32'hDEADBEEF; pc_in = 32'h100;
        step();
        checks++;
        if (tag_out !== 8'd1 || pc_out !== 32'h100 || retired_out !== 64'd1) begin
            errors++; $display("FAIL basic_commit: tag=%h pc=%h ret=%0d expected 01/100/1", tag_out, pc_out, retired_out);
        end
        rs1_idx = 5'd5;
        step();
        checks++;
        if (rs1_out !== 32'hDEADBEEF) begin
            errors++; $display("FAIL basic_read: got %h expected deadbeef", rs1_out);
        end
    endtask

    task automatic test_x0_and_hold();
        tag = 8'd2; rd_idx = 5'd0; rd_val = 32'hFFFFFFFF; pc_in = 32'h104; rs1_idx = 5'd0;
        step();
        checks++;
        if (tag_out !== 8'd2 || retired_out !== 64'd2 || pc_out !== 32'h104) begin
            errors++; $display("FAIL x0_commit: tag=%h pc=%h ret=%0d expected 02/104/2", tag_out, pc_out, retired_out);
        end
        step();
        checks++;
        if (rs1_out !== 32'h0) begin
            errors++; $display("FAIL x0_read: got %h expected 0", rs1_out);
        end
        rd_idx = 5'd5;
        for (int c = 0; c < 10; c++) begin
            rd_val = 32'hA0A0_0000 + c;
            pc_in  = 32'h900 + c;
            step();
            checks++;
            if (retired_out !== 64'd2 || pc_out !== 32'h104 || tag_out !== 8'd2) begin
                errors++; $display("FAIL hold_tag c%0d: ret=%0d pc=%h tag=%h expected 2/104/02", c, retired_out, pc_out, tag_out);
            end
        end
        rs1_idx = 5'd5;
        step();
        checks++;
        if (rs1_out !== 32'hDEADBEEF) begin
            errors++; $display("FAIL hold_no_write: x5=%h expected deadbeef", rs1_out);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
        tag = 8'd3; rd_idx = 5'd7; rd_val = 32'hAAAA5555; pc_in = 32'h108; rs2_idx = 5'd0;
        step();
        tag = 8'd4; rd_idx = 5'd7; rd_val = 32'h12345678; pc_in = 32'h10C; rs2_idx = 5'd7;
        step();
`ifdef RV32_REGFILE_BYPASS_EN
        exp_same = 32'h12345678;
`else
        exp_same = 32'hAAAA5555;
`endif
        checks++;
        if (rs2_out !== exp_same) begin
            errors++; $display("FAIL bypass_same_edge: got %h expected %h", rs2_out, exp_same);
        end
        step();
        checks++;
        if (rs2_out !== 32'h12345678) begin
            errors++; $display("FAIL bypass_next_read: got %h expected 12345678", rs2_out);
        end
        checks++;
        if (retired_out !== 64'd4) begin
            errors++; $display("FAIL bypass_count: got %0d expected 4", retired_out);
        end
    endtask

    task automatic test_back_to_back_reset();
        rs1_idx = 5'd0; rs2_idx = 5'd0;
        for (int i = 0; i < 20; i++) begin
            tag = 8'(5 + i); rd_idx = 5'(i + 1); rd_val = 32'h1000_0000 + i; pc_in = 32'h300 + 4 * i;
            step();
            checks++;
            if (retired_out !== 64'(5 + i) || tag_out !== 8'(5 + i) || pc_out !== 32'h300 + 4 * i) begin
                errors++; $display("FAIL stream i%0d: ret=%0d tag=%h pc=%h expected %0d/%h/%h",
                                   i, retired_out, tag_out, pc_out, 5 + i, 5 + i, 32'h300 + 4 * i);
            end
        end
        rs1_idx = 5'd5;
        step();
        checks++;
        if (rs1_out !== 32'h1000_0004) begin
            errors++; $display("FAIL stream_read x5: got %h expected 10000004", rs1_out);
        end
        rst_n = 1'b0; tag = 8'd0;
        step();
        checks++;
        if ({rs1_out, rs2_out, tag_out, pc_out, retired_out, ready_out} !== '0) begin
            errors++; $display("FAIL midreset_values: rs1=%h rs2=%h tag=%h pc=%h ret=%h rdy=%b (all must be 0)",
                               rs1_out, rs2_out, tag_out, pc_out, retired_out, ready_out);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            step();
            checks++;
            if (ready_out !== (k == 31) || rs1_out !== 32'h0) begin
                errors++; $display("FAIL resweep edge %0d: rdy=%b rs1=%h expected %b/0", k, ready_out, rs1_out, (k == 31));
            end
        end
    endtask

    task automatic test_tag_during_clear();
        rst_n = 1'b0; tag = 8'd0; rs1_idx = 5'd0;
        step();
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            if (k == 10) begin
                tag = 8'd3; rd_idx = 5'd9; rd_val = 32'h0000_0099; pc_in = 32'h200;
            end
            step();
            checks++;
            if (tag_out !== 8'd0 || retired_out !== 64'd0) begin
                errors++; $display("FAIL clear_ignores_tag edge %0d: tag=%h ret=%0d expected 0/0", k, tag_out, retired_out);
            end
        end
        step();
        checks++;
        if (tag_out !== 8'd3 || retired_out !== 64'd1 || pc_out !== 32'h200) begin
            errors++; $display("FAIL first_ready_consume: tag=%h ret=%0d pc=%h expected 03/1/200", tag_out, retired_out, pc_out);
        end
        rs1_idx = 5'd9; rs2_idx = 5'd3;
        step();
        checks++;
        if (rs1_out !== 32'h99 || rs2_out !== 32'h0) begin
            errors++; $display("FAIL post_clear_read: x9=%h x3=%h expected 99/0", rs1_out, rs2_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_x0_and_hold();
        test_bypass();
        test_back_to_back_reset();
        test_tag_during_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
